// File: rtl/max_pool_pkg.sv
// Shared types and constants for the max-pool sequencers.
package max_pool_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Words are 4 bytes, so a word index becomes a byte address by shifting left 2.
  localparam int          BYTE_SHIFT = 2;
  localparam logic [3:0]  WE_ALL     = 4'hF;

  // Bit k holds the row (dy) / column (dx) offset of window tap k:
  // tap 0..3 -> (0,0) (0,1) (1,0) (1,1).
  localparam logic [3:0]  TAP_DY     = 4'b1100;
  localparam logic [3:0]  TAP_DX     = 4'b1010;

  // Counter width for a given bound, never narrower than one bit.
  function automatic int cnt_w(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/max_pool_1_ctrl_max4.sv
// Registered signed running maximum: load takes the first sample,
// update keeps the larger of the stored value and the new sample.
module pool_max4 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              update,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] max_q
);

  // Running-max register; load wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (load) begin
      max_q <= din;
    end else if (update && ($signed(din) > $signed(max_q))) begin
      max_q <= din;
    end
  end

endmodule

// File: rtl/max_pool_1_ctrl.sv
// Sequencer for the first 2x2/stride-2 max-pool stage: reads four source
// words per output pixel, writes their signed maximum to the pooled BRAM.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; counters cleared when start is taken
// RD    | issue source read for the current tap (4 cycles)
// CAP   | fold in the last tap's read data
// WR    | write the window maximum to the pooled BRAM (1 cycle)
// DONE  | one-cycle done pulse, then back to IDLE
module max_pool_1_ctrl
  import max_pool_pkg::*;
#(
  parameter int          IN_W     = 28,
  parameter int          IN_H     = 28,
  parameter int          CHANNELS = 8,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] SRC_BASE = 32'h0,
  parameter logic [31:0] DST_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       src_addr,
  output logic              src_en,
  input  logic [DATA_W-1:0] src_dout,
  output logic [31:0]       dst_addr,
  output logic              dst_en,
  output logic [3:0]        dst_we,
  output logic [DATA_W-1:0] dst_din
);

  localparam int OW = IN_W / 2;
  localparam int OH = IN_H / 2;
  localparam int XW = cnt_w(OW);
  localparam int RW = cnt_w(OH);
  localparam int CW = cnt_w(CHANNELS);

  localparam logic [XW-1:0] X_LAST = XW'(OW - 1);
  localparam logic [RW-1:0] R_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      tap_q;
  logic [XW-1:0]   x_q;
  logic [RW-1:0]   r_q;
  logic [CW-1:0]   c_q;
  logic            last_out;
  logic            max_load;
  logic            max_update;
  logic [DATA_W-1:0] max_q;
  logic [31:0]     src_index;
  logic [31:0]     dst_index;

  assign last_out = (c_q == C_LAST) && (r_q == R_LAST) && (x_q == X_LAST);

  // Read data lags src_en by one cycle: tap 1 sees tap 0's word (load),
  // taps 2..3 and CAP see taps 1..3 (compare-and-update).
  assign max_load   = (state_q == RD) && (tap_q == 2'd1);
  assign max_update = ((state_q == RD) && (tap_q[1] == 1'b1)) || (state_q == CAP);

  assign src_index = 32'(c_q) * 32'(IN_W * IN_H)
                   + (32'(r_q) * 32'd2 + 32'(TAP_DY[tap_q])) * 32'(IN_W)
                   + 32'(x_q) * 32'd2 + 32'(TAP_DX[tap_q]);
  assign dst_index = (32'(c_q) * 32'(OH) + 32'(r_q)) * 32'(OW) + 32'(x_q);

  pool_max4 #(.DATA_W(DATA_W)) u_max4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (max_load),
    .update (max_update),
    .din    (src_dout),
    .max_q  (max_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RD;
      RD:      if (tap_q == 2'd3) state_d = CAP;
      CAP:     state_d = WR;
      WR:      state_d = last_out ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap and pixel counters: cleared on frame start, x fastest then r then c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
      x_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            tap_q <= '0;
            x_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
          end
        end
        // 2-bit tap rolls 3 -> 0, ready for the next window.
        RD: tap_q <= tap_q + 2'd1;
        WR: begin
          if (!last_out) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (r_q == R_LAST) begin
                r_q <= '0;
                c_q <= c_q + CW'(1);
              end else begin
                r_q <= r_q + RW'(1);
              end
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; everything idles at zero.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    src_en   = 1'b0;
    src_addr = '0;
    dst_en   = 1'b0;
    dst_we   = '0;
    dst_addr = '0;
    dst_din  = '0;
    case (state_q)
      RD: begin
        busy     = 1'b1;
        src_en   = 1'b1;
        src_addr = SRC_BASE + (src_index << BYTE_SHIFT);
      end
      CAP: busy = 1'b1;
      WR: begin
        busy     = 1'b1;
        dst_en   = 1'b1;
        dst_we   = WE_ALL;
        dst_addr = DST_BASE + (dst_index << BYTE_SHIFT);
        dst_din  = max_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_max_pool_1_ctrl.sv
module tb_max_pool_1_ctrl;

  localparam int          IN_W   = 4;
  localparam int          IN_H   = 4;
  localparam int          CH     = 2;
  localparam int          OW     = IN_W / 2;
  localparam int          OH     = IN_H / 2;
  localparam int          NOUT   = OW * OH * CH;
  localparam int          NWORDS = IN_W * IN_H * CH;
  localparam logic [31:0] SB     = 32'h100;
  localparam logic [31:0] DB     = 32'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, src_en, dst_en;
  logic [31:0] src_addr, dst_addr, dst_din;
  logic [31:0] src_dout = '0;
  logic [3:0]  dst_we;

  max_pool_1_ctrl #(
    .IN_W(IN_W), .IN_H(IN_H), .CHANNELS(CH), .DATA_W(32),
    .SRC_BASE(SB), .DST_BASE(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .src_addr(src_addr), .src_en(src_en), .src_dout(src_dout),
    .dst_addr(dst_addr), .dst_en(dst_en), .dst_we(dst_we), .dst_din(dst_din)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NWORDS];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [31:0] rd_q [$];
  logic [63:0] wr_q [$];
  int          done_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Source BRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (src_en) begin
      int idx;
      idx = int'((src_addr - SB) >> 2);
      if (idx >= 0 && idx < NWORDS) src_dout <= mem[idx];
      else                          src_dout <= 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: for every pooled pixel, the four window reads in tap order,
  // the signed maximum with its destination address, and the done cycle.
  task automatic push_frame(input int s);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < OH; r++)
        for (int x = 0; x < OW; x++) begin
          logic signed [31:0] m;
          int o;
          m = '0;
          for (int k = 0; k < 4; k++) begin
            int dy, dx, idx;
            dy  = k / 2;
            dx  = k % 2;
            idx = c * IN_W * IN_H + (2 * r + dy) * IN_W + 2 * x + dx;
            rd_q.push_back(SB + 32'(4 * idx));
            if (k == 0 || $signed(mem[idx]) > m) m = mem[idx];
          end
          o = (c * OH + r) * OW + x;
          wr_q.push_back({DB + 32'(4 * o), m});
        end
    done_q.push_back(s + 6 * NOUT + 1);
  endtask

  task automatic flush();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic do_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    push_frame(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_q.size() != 0) begin
      fail("timeout_waiting_done");
      flush();
    end
    @(negedge clk);
    check("reads_left", 64'(rd_q.size()), 64'd0);
    check("writes_left", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic run_frame();
    int s;
    do_start(s);
    wait_done(6 * NOUT + 20);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    mem[$urandom_range(0, NWORDS - 1)] = 32'h8000_0000;
    mem[$urandom_range(0, NWORDS - 1)] = 32'h7FFF_FFFF;
    mem[$urandom_range(0, NWORDS - 1)] = 32'hFFFF_FFFF;
  endtask

  // Monitor: compares every DUT read, write and done pulse with the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (src_en) begin
        check("busy_during_read", 64'(busy), 64'd1);
        if (rd_q.size() == 0) fail("unexpected_src_read");
        else check("src_addr", 64'(src_addr), 64'(rd_q.pop_front()));
      end
      if (dst_en) begin
        wr_cnt++;
        check("dst_we", 64'(dst_we), 64'hF);
        if (wr_q.size() == 0) fail("unexpected_dst_write");
        else check("dst_addr_din", {dst_addr, dst_din}, wr_q.pop_front());
      end else begin
        check("dst_we_idle", 64'(dst_we), 64'd0);
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 64'(busy), 64'd0);
        if (done_q.size() == 0) fail("unexpected_done");
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  initial begin
    int s;
    for (int i = 0; i < NWORDS; i++) mem[i] = 32'(i);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_src_en", 64'(src_en), 64'd0);
    check("rst_dst_en", 64'(dst_en), 64'd0);
    check("rst_dst_we", 64'(dst_we), 64'd0);
    check("rst_addrs", {src_addr, dst_addr}, 64'd0);
    check("rst_dst_din", 64'(dst_din), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp data: channel 0 gives 5,7,13,15; channel 1 first read at 0x140, write at 0x50.
    run_frame();

    // Negative window in the first output: max of {-8,-3,-5,-9} is -3.
    fill_random();
    mem[0] = -32'sd8; mem[1] = -32'sd3; mem[4] = -32'sd5; mem[5] = -32'sd9;
    run_frame();

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      fill_random();
      run_frame();
    end

    // start pulsed while busy is ignored.
    fill_random();
    wr_cnt = 0;
    done_cnt = 0;
    do_start(s);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6 * NOUT + 20);
    repeat (10) @(negedge clk);
    check("busy_start_writes", 64'(wr_cnt), 64'(NOUT));
    check("busy_start_dones", 64'(done_cnt), 64'd1);

    // Reset mid-frame.
    fill_random();
    do_start(s);
    while (cyc < s + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    flush();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_en", {62'd0, src_en, dst_en}, 64'd0);
    check("midrst_outs", {dst_din, dst_addr | src_addr | 32'(dst_we)}, 64'd0);
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_writes", 64'(wr_cnt), 64'd0);
    fill_random();
    run_frame();

    // Back-to-back frames with start held high.
    fill_random();
    done_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    push_frame(s);
    push_frame(s + 6 * NOUT + 2);
    while (cyc < s + 6 * NOUT + 3) @(negedge clk);
    start = 1'b0;
    wait_done(6 * NOUT + 20);
    check("b2b_dones", 64'(done_cnt), 64'd2);
    check("b2b_writes", 64'(wr_cnt), 64'(2 * NOUT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
